// File: rtl/pi_pkg.sv
// Shared definitions for the PI control loop: state encoding and default data widths.
package pi_pkg;

  localparam int DEFAULT_INPUT_WIDTH  = 18;
  localparam int DEFAULT_OUTPUT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } pi_state_e;

endpackage

// File: rtl/pi_sat_clamp.sv
// Signed symmetric clamp of a W-bit value to [-limit, +limit]; limit is unsigned and
// anything at or above 2^(W-1) is treated as the largest positive W-bit value.
module pi_sat_clamp #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] limit,
  output logic [W-1:0] result
);

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0]        lim_eff;
  logic signed [W:0]   value_ext;
  logic signed [W:0]   pos_bound;
  logic signed [W:0]   neg_bound;

  // Bounds live in W+1 bits so that negating the limit can never overflow.
  always_comb begin
    lim_eff   = limit[W-1] ? MAX_POS : limit;
    value_ext = $signed({value[W-1], value});
    pos_bound = $signed({1'b0, lim_eff});
    neg_bound = -pos_bound;
    if (value_ext > pos_bound) begin
      result = lim_eff;
    end else if (value_ext < neg_bound) begin
      result = neg_bound[W-1:0];
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/pi_loop_sequencer.sv
// Sequences one PI loop iteration per ADC sample: holds pipeline inputs, waits out the
// pipeline latency, captures the clamped integral and PI result, hands the result to the DAC.
module pi_loop_sequencer
  import pi_pkg::*;
#(
  parameter int INPUT_WIDTH   = DEFAULT_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH  = DEFAULT_OUTPUT_WIDTH,
  parameter int PIPE_LATENCY  = 5,
  parameter int OVERRUN_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     integral_clear,
  input  logic [INPUT_WIDTH-1:0]   setpoint,
  input  logic [OUTPUT_WIDTH-1:0]  integral_limit,
  input  logic [INPUT_WIDTH-1:0]   adc_data,
  input  logic                     adc_valid,
  output logic [INPUT_WIDTH-1:0]   pipe_setpoint,
  output logic [INPUT_WIDTH-1:0]   pipe_actual,
  output logic [OUTPUT_WIDTH-1:0]  pipe_integral_input,
  input  logic [OUTPUT_WIDTH-1:0]  pipe_integral_result,
  input  logic [OUTPUT_WIDTH-1:0]  pipe_pi_result,
  output logic [OUTPUT_WIDTH-1:0]  dac_data,
  output logic                     dac_valid,
  input  logic                     dac_ready,
  output logic                     busy,
  output logic [OVERRUN_WIDTH-1:0] overrun_count,
  output pi_state_e                state_dbg
);

  // DAC handshake: dac_data is offered while dac_valid is high and is held unchanged
  // until the cycle dac_ready is also high; that cycle is the transfer and dac_valid drops after it.

  localparam int CW = $clog2(PIPE_LATENCY) + 1;
  localparam logic [CW-1:0] CAPTURE_AT = CW'(PIPE_LATENCY - 1);
  localparam logic [OVERRUN_WIDTH-1:0] OVERRUN_MAX = '1;

  pi_state_e               state_q, state_d;
  logic [CW-1:0]           count_q;
  logic [OUTPUT_WIDTH-1:0] integral_q;
  logic [OUTPUT_WIDTH-1:0] integral_clamped;
  logic                    accept;
  logic                    capture;
  logic                    drop;

  pi_sat_clamp #(.W(OUTPUT_WIDTH)) u_clamp (
    .value  (pipe_integral_result),
    .limit  (integral_limit),
    .result (integral_clamped)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (adc_valid) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Losing enable mid-flight abandons the iteration without touching the integral.
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (count_q == CAPTURE_AT) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (dac_ready) state_d = enable ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign drop = adc_valid && ((state_q == ST_RUN) || (state_q == ST_OUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      pipe_setpoint <= '0;
      pipe_actual   <= '0;
      integral_q    <= '0;
      dac_data      <= '0;
      overrun_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pipe_actual   <= adc_data;
        pipe_setpoint <= setpoint;
        count_q       <= '0;
      end else if (state_q == ST_RUN) begin
        count_q <= count_q + CW'(1);
      end
      if (capture) dac_data <= pipe_pi_result;
      // Clear beats a coincident capture.
      if (integral_clear) begin
        integral_q <= '0;
      end else if (capture) begin
        integral_q <= integral_clamped;
      end
      if (drop && (overrun_count != OVERRUN_MAX)) begin
        overrun_count <= overrun_count + OVERRUN_WIDTH'(1);
      end
    end
  end

  assign pipe_integral_input = integral_q;
  assign dac_valid           = (state_q == ST_OUT);
  assign busy                = (state_q == ST_RUN) || (state_q == ST_OUT);
  assign state_dbg           = state_q;

endmodule

// File: doc/pi_loop_sequencer.md
Name: pi_loop_sequencer

Overview:
- Control-loop sequencer that sits directly upstream of the PI pipeline and also consumes its outputs.
- Accepts one ADC sample per loop iteration and presents setpoint, actual and the stored integral to the pipeline, holding them stable.
- Waits a fixed pipeline latency, then captures the integral result with anti-windup clamping and the PI result.
- Delivers the PI result to the DAC writer over a valid/ready handshake; counts samples dropped while busy.

Parameters:
INPUT_WIDTH, 18, ADC sample / setpoint width
OUTPUT_WIDTH, 32, integral and PI result width
PIPE_LATENCY, 5, cycles from stable pipeline inputs to valid pi_result (must be >= 2)
OVERRUN_WIDTH, 16, overrun counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  loop run enable
integral_clear  in  1  zero the stored integral
setpoint  in  INPUT_WIDTH  target value, sampled at sample accept
integral_limit  in  OUTPUT_WIDTH  anti-windup magnitude bound; treated as unsigned, values >= 2^(OUTPUT_WIDTH-1) saturate to the max positive value
adc_data  in  INPUT_WIDTH  signed ADC sample
adc_valid  in  1  sample strobe, one cycle, no backpressure
pipe_setpoint  out  INPUT_WIDTH  to pipeline setpoint
pipe_actual  out  INPUT_WIDTH  to pipeline actual
pipe_integral_input  out  OUTPUT_WIDTH  to pipeline integral_input
pipe_integral_result  in  OUTPUT_WIDTH  from pipeline integral_result
pipe_pi_result  in  OUTPUT_WIDTH  from pipeline pi_result
dac_data  out  OUTPUT_WIDTH  PI result to DAC writer
dac_valid  out  1  dac_data valid
dac_ready  in  1  DAC writer accepts
busy  out  1  state != IDLE and state != WAIT
overrun_count  out  OVERRUN_WIDTH  saturating count of dropped samples

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - All pipe_* outputs, dac_data, the integral register and overrun_count = 0.
  - dac_valid = 0, busy = 0.
- States: IDLE, WAIT, RUN, OUT.
  - IDLE: enable=1 -> WAIT.
  - WAIT: adc_valid=1 -> latch adc_data into pipe_actual and setpoint into pipe_setpoint; pipe_integral_input continuously mirrors the integral register; count=0; -> RUN.
  - RUN: count increments each cycle. When count == PIPE_LATENCY-1:
    - Capture pipe_pi_result into dac_data.
    - Capture pipe_integral_result, clamped to [-L, +L] with L = integral_limit, into the integral register.
    - Assert dac_valid; -> OUT.
  - OUT: dac_valid held high and dac_data held stable until dac_ready=1. On that cycle dac_valid drops; -> WAIT if enable=1, else IDLE.
- Latency: sample accepted at cycle N -> dac_valid high at cycle N+PIPE_LATENCY+1.
- Pipeline inputs are never changed in RUN or OUT.
- Overrun: adc_valid in RUN or OUT -> sample dropped, overrun_count += 1, saturating at all-ones. adc_valid in IDLE is ignored and not counted.
- enable deasserted:
  - In WAIT -> IDLE next cycle.
  - In RUN -> abort to IDLE; no output, integral register unchanged.
  - In OUT -> the current handshake completes, then IDLE.
- integral_clear:
  - Zeroes the integral register in any state.
  - If it coincides with the RUN capture cycle, clear wins (register = 0); dac_data is still captured.
- Clamp arithmetic: signed compare of the OUTPUT_WIDTH result against +L and -L; -L is computed in OUTPUT_WIDTH+1 bits to avoid overflow.
- rst mid-operation: immediate return to reset values; any pending dac_valid is dropped.

Decomposition:
- Shared package pi_pkg:
  - State encoding enum (IDLE/WAIT/RUN/OUT).
  - Default widths (INPUT_WIDTH=18, OUTPUT_WIDTH=32), shared with pi_pipeline.
- One natural sub-module, pi_sat_clamp: parameterised signed symmetric clamp, combinational, reusable for DAC range clamping.
- Counter and FSM stay in the top module.

Test Plan:
- Basic loop: limit=1000, integral=0, setpoint=100, adc=150, kp=1, ki=1 on a connected pipeline -> dac_valid at accept+6 with dac_data=100; integral register=50.
- Anti-windup: limit=40, same stimulus -> integral=40. Repeat with adc=-500 -> integral=-40.
- Backpressure: hold dac_ready=0 for 10 cycles -> dac_valid and dac_data stable throughout; transfer occurs on the ready cycle; next sample accepted thereafter.
- Overrun: pulse adc_valid 3 times during RUN -> overrun_count=3. Preload near saturation and pulse again -> stays at 0xFFFF.
- Abort: deassert enable at RUN count 2 -> IDLE, dac_valid never asserts, integral unchanged. Clear coinciding with the capture cycle -> integral=0, dac_data still updated.
- Reset mid-OUT with dac_valid=1 -> next cycle dac_valid=0, state IDLE, overrun_count=0.
